// File: rtl/alu_pkg.sv
// Shared types for the clocked ALU execution unit.
package alu_pkg;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} alu_op_e;

  typedef enum logic [1:0] {IDLE, DIV, DONE} alu_state_e;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first, WIDTH steps.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quot_q, rem_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quot_n, rem_n;

  // The final step is presented combinationally so the caller can retire on the same edge.
  always_comb begin
    trial = {rem_q, quot_q[WIDTH-1]} - {1'b0, dvs_q};
    if (!trial[WIDTH]) begin
      rem_n  = trial[WIDTH-1:0];
      quot_n = {quot_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_n  = {rem_q[WIDTH-2:0], quot_q[WIDTH-1]};
      quot_n = {quot_q[WIDTH-2:0], 1'b0};
    end
  end

  assign done      = (cnt_q == CW'(1));
  assign quotient  = quot_n;
  assign remainder = rem_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      quot_q <= dividend;
      rem_q  <= '0;
      dvs_q  <= divisor;
      cnt_q  <= CW'(WIDTH);
    end else if (cnt_q != '0) begin
      quot_q <= quot_n;
      rem_q  <= rem_n;
      cnt_q  <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Clocked add/sub/mul/div unit with handshake issue and an internal write-back register file.
//  state | meaning
//  IDLE  | waiting for a request, in_ready high
//  DIV   | divider iterating, requests held off
//  DONE  | result valid for one cycle, new request may issue
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int NREG  = 16,
  localparam int AW    = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       f0,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic             cin,
  input  logic             bin,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rem,
  output logic             cout,
  output logic             ovf,
  output logic             div0,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  alu_state_e       state;
  alu_op_e          op;
  logic [AW-1:0]    wb_q, wr_idx;
  logic [WIDTH-1:0] regs [NREG];

  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   nx_out, nx_rem, quot, remd;
  logic               nx_cout, nx_ovf, nx_div0;
  logic               ld, start_div, div_done, wr_en;

  assign op       = alu_op_e'(f0);
  assign in_ready = (state != DIV);

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (start_div),
    .dividend  (inp1),
    .divisor   (inp2),
    .done      (div_done),
    .quotient  (quot),
    .remainder (remd)
  );

  always_comb begin
    sum       = {1'b0, inp1} + {1'b0, inp2} + (WIDTH+1)'(cin);
    diff      = {1'b0, inp1} - {1'b0, inp2} - (WIDTH+1)'(bin);
    prod      = {{WIDTH{1'b0}}, inp1} * {{WIDTH{1'b0}}, inp2};
    nx_out    = '0;
    nx_rem    = '0;
    nx_cout   = 1'b0;
    nx_ovf    = 1'b0;
    nx_div0   = 1'b0;
    ld        = 1'b0;
    start_div = 1'b0;
    wr_idx    = wb_addr;
    if (state == DIV) begin
      if (div_done) begin
        ld     = 1'b1;
        nx_out = quot;
        nx_rem = remd;
        wr_idx = wb_q;
      end
    end else if (in_valid) begin
      case (op)
        OP_ADD: begin
          ld      = 1'b1;
          nx_out  = sum[WIDTH-1:0];
          nx_cout = sum[WIDTH];
        end
        OP_SUB: begin
          ld      = 1'b1;
          nx_out  = diff[WIDTH-1:0];
          nx_cout = diff[WIDTH];
        end
        OP_MUL: begin
          ld     = 1'b1;
          nx_out = prod[WIDTH-1:0];
          nx_ovf = (prod[2*WIDTH-1:WIDTH] != '0);
        end
        OP_DIV: begin
          if (inp2 == '0) begin
            ld      = 1'b1;
            nx_out  = '1;
            nx_rem  = inp1;
            nx_div0 = 1'b1;
          end else begin
            start_div = 1'b1;
          end
        end
      endcase
    end
  end

  // Indices beyond the file depth are accepted but never written.
  assign wr_en = ld && (int'(wr_idx) < NREG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wb_q      <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      rem       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      div0      <= 1'b0;
    end else begin
      out_valid <= ld;
      if (ld) begin
        state <= DONE;
        out   <= nx_out;
        rem   <= nx_rem;
        cout  <= nx_cout;
        ovf   <= nx_ovf;
        div0  <= nx_div0;
      end else if (start_div) begin
        state <= DIV;
        wb_q  <= wb_addr;
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_idx] <= nx_out;
    end
  end

  assign rd_data = (int'(rd_addr) < NREG) ? regs[rd_addr] : '0;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with an arithmetic reference model and per-cycle compare.
module tb_alu_exec_unit;

  localparam int W  = 16;
  localparam int NR = 12;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    f0 = 2'd0;
  logic [AW-1:0] wb_addr = '0;
  logic [W-1:0]  inp1 = '0, inp2 = '0;
  logic          cin = 1'b0, bin = 1'b0;
  logic          out_valid;
  logic [W-1:0]  out, rem;
  logic          cout, ovf, div0;
  logic [AW-1:0] rd_addr = '0;
  logic [W-1:0]  rd_data;

  alu_exec_unit #(.WIDTH(W), .NREG(NR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .f0(f0),
    .wb_addr(wb_addr), .inp1(inp1), .inp2(inp2), .cin(cin), .bin(bin),
    .out_valid(out_valid), .out(out), .rem(rem), .cout(cout), .ovf(ovf),
    .div0(div0), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          long_op;
    logic [15:0] out;
    logic [15:0] rem;
    logic        cout;
    logic        ovf;
    logic        div0;
    int          addr;
  } exp_t;

  exp_t        q[$];
  logic [15:0] shadow [NR];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          started = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic exp_t model(input int op, input longint a, input longint b,
                                 input int c, input int bi);
    exp_t e;
    longint p;
    e.due = 0; e.long_op = 0; e.rem = '0; e.cout = 0; e.ovf = 0; e.div0 = 0; e.addr = 0;
    e.out = '0;
    case (op)
      0: begin p = a + b + c; e.out = 16'(p % 65536); e.cout = (p >= 65536); end
      1: begin e.out = 16'((a - b - bi + 65536) % 65536); e.cout = (a < b + bi); end
      2: begin p = a * b; e.out = 16'(p % 65536); e.ovf = ((p / 65536) != 0); end
      default: begin
        if (b == 0) begin e.out = 16'hFFFF; e.rem = 16'(a); e.div0 = 1; end
        else begin e.out = 16'(a / b); e.rem = 16'(a % b); e.long_op = 1; end
      end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && started) begin
      chk("in_ready", {31'd0, in_ready},
          {31'd0, !(q.size() > 0 && q[0].long_op && cyc < q[0].due)});
      if (q.size() > 0 && q[0].due <= cyc) begin
        chk("out_valid_hi", {31'd0, out_valid}, 32'd1);
        chk("out", {16'd0, out}, {16'd0, q[0].out});
        chk("rem", {16'd0, rem}, {16'd0, q[0].rem});
        chk("cout", {31'd0, cout}, {31'd0, q[0].cout});
        chk("ovf", {31'd0, ovf}, {31'd0, q[0].ovf});
        chk("div0", {31'd0, div0}, {31'd0, q[0].div0});
        if (q[0].addr < NR) shadow[q[0].addr] = q[0].out;
        void'(q.pop_front());
      end else begin
        chk("out_valid_lo", {31'd0, out_valid}, 32'd0);
      end
      chk("rd_data", {16'd0, rd_data}, {16'd0, shadow[int'(rd_addr)]});
      rd_addr = AW'((int'(rd_addr) + 1) % NR);
    end
  end

  task automatic issue(input int op, input int a, input int b, input int c, input int bi,
                       input int addr);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    f0 = 2'(op); inp1 = 16'(a); inp2 = 16'(b); cin = 1'(c); bin = 1'(bi);
    wb_addr = AW'(addr); in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    e = model(op, a, b, c, bi);
    e.addr = addr;
    e.due  = cyc + (e.long_op ? W : 0);
    q.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("drain_timeout", 32'd1, 32'd0);
    @(negedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, act, exp);
  endtask

  initial begin
    exp_t m;
    for (int i = 0; i < NR; i++) shadow[i] = '0;
    #1;
    lit("rst_out_valid", {31'd0, out_valid}, 32'd0);
    lit("rst_out", {16'd0, out}, 32'd0);
    lit("rst_flags", {29'd0, cout, ovf, div0}, 32'd0);
    lit("rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    started = 1;

    m = model(0, 'hFFFF, 1, 0, 0);
    lit("model_add", {15'd0, m.cout, m.out}, 32'h0001_0000);
    m = model(1, 5, 7, 0, 1);
    lit("model_sub", {15'd0, m.cout, m.out}, 32'h0001_FFFD);
    m = model(2, 'h0100, 'h0100, 0, 0);
    lit("model_mul", {15'd0, m.ovf, m.out}, 32'h0001_0000);
    m = model(3, 100, 7, 0, 0);
    lit("model_div", {m.out, m.rem}, {16'd14, 16'd2});

    issue(0, 'h1234, 0, 0, 0, 3);
    issue(0, 'hFFFF, 1, 0, 0, 3);
    wait_idle();
    lit("add_out", {15'd0, cout, out}, 32'h0001_0000);

    issue(1, 5, 7, 0, 1, 4);
    wait_idle();
    lit("sub_out", {15'd0, cout, out}, 32'h0001_FFFD);
    issue(2, 'h0100, 'h0100, 0, 0, 5);
    wait_idle();
    lit("mul_out", {15'd0, ovf, out}, 32'h0001_0000);
    lit("mul_hold", {31'd0, out_valid}, 32'd0);

    issue(0, 'h00F0, 'h000F, 1, 0, 2);
    issue(1, 'h0009, 'h0003, 0, 0, 1);
    issue(2, 'h00FF, 'h0101, 0, 0, 0);
    wait_idle();

    issue(3, 100, 7, 0, 0, 6);
    wait_idle();
    lit("div_out", {out, rem}, {16'd14, 16'd2});

    issue(3, 'h1234, 0, 0, 0, 7);
    wait_idle();
    lit("div0_out", {out, rem}, 32'hFFFF_1234);
    lit("div0_flag", {31'd0, div0}, 32'd1);

    issue(3, 1000, 3, 0, 0, 8);
    issue(0, 'h0011, 'h0022, 0, 0, 9);
    issue(3, 5, 9, 0, 0, 10);
    issue(3, 'hFFFF, 1, 0, 0, 11);
    issue(0, 'hAAAA, 'h5555, 1, 0, 13);
    wait_idle();
    lit("oor_out", {15'd0, cout, out}, 32'h0001_0000);

    issue(3, 'hBEEF, 'h0013, 0, 0, 10);
    repeat (7) @(negedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    for (int i = 0; i < NR; i++) shadow[i] = '0;
    #1;
    lit("mid_rst_outs", {out, rem}, 32'd0);
    lit("mid_rst_ready", {28'd0, in_ready, out_valid, cout, div0}, 32'h8);
    @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (NR + 2) @(negedge clk);
    issue(0, 'h0001, 'h0002, 1, 0, 1);
    wait_idle();
    lit("post_rst_add", {15'd0, cout, out}, 32'h0000_0004);
    repeat (NR + 2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
